// File: rtl/aes128_enc_iter_ctrl_if.sv
// rtl/aes128_enc_iter_ctrl_if.sv - job/result handshake bundle for the iterative AES-128 encryptor
interface aes128_enc_iter_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
    logic [3:0]   round_idx;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy, round_idx
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy, round_idx
    );
endinterface

// File: rtl/aes128_enc_iter_ctrl.sv
// rtl/aes128_enc_iter_ctrl.sv - iterative AES-128 encryptor, one round per clock, on-the-fly key expansion
module aes128_enc_iter_ctrl (
    input  logic                         clk,
    input  logic                         rst_n,
    aes128_enc_iter_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[i*8 +: 8] = sbox(s[i*8 +: 8]);
        return o;
    endfunction

    // Byte n of the column-major state lives at [127-8n -: 8]; row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    fsm_t         r_fsm,   w_fsm_d;
    logic [127:0] r_state, w_state_d;
    logic [127:0] r_rkey,  w_rkey_d;
    logic [3:0]   r_round, w_round_d;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_w4, w_w5, w_w6, w_w7, w_t;
    logic [127:0] w_rk_next;
    logic [127:0] w_sr, w_full, w_last;

    assign {w_w0, w_w1, w_w2, w_w3} = r_rkey;
    assign w_t = {sbox(w_w3[23:16]), sbox(w_w3[15:8]), sbox(w_w3[7:0]), sbox(w_w3[31:24])}
               ^ {rcon(r_round), 24'h0};
    assign w_w4 = w_w0 ^ w_t;
    assign w_w5 = w_w1 ^ w_w4;
    assign w_w6 = w_w2 ^ w_w5;
    assign w_w7 = w_w3 ^ w_w6;
    assign w_rk_next = {w_w4, w_w5, w_w6, w_w7};

    // SubBytes/ShiftRows are shared; the final round just skips MixColumns.
    assign w_sr   = shift_rows(sub_bytes(r_state));
    assign w_full = mix_columns(w_sr) ^ w_rk_next;
    assign w_last = w_sr ^ w_rk_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= S_IDLE;
            r_state <= 128'h0;
            r_rkey  <= 128'h0;
            r_round <= 4'd0;
        end else begin
            r_fsm   <= w_fsm_d;
            r_state <= w_state_d;
            r_rkey  <= w_rkey_d;
            r_round <= w_round_d;
        end
    end

    always_comb begin
        w_fsm_d   = r_fsm;
        w_state_d = r_state;
        w_rkey_d  = r_rkey;
        w_round_d = r_round;
        case (r_fsm)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_d = bus.plaintext ^ bus.key;
                    w_rkey_d  = bus.key;
                    w_round_d = 4'd1;
                    w_fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                if (r_round > 4'd10) begin
                    w_round_d = 4'd0;
                    w_fsm_d   = S_IDLE;
                end else if (r_round == 4'd10) begin
                    w_state_d = w_last;
                    w_rkey_d  = w_rk_next;
                    w_fsm_d   = S_DONE;
                end else begin
                    w_state_d = w_full;
                    w_rkey_d  = w_rk_next;
                    w_round_d = r_round + 4'd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_round_d = 4'd0;
                    w_fsm_d   = S_IDLE;
                end
            end
            default: begin
                w_round_d = 4'd0;
                w_fsm_d   = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready   = (r_fsm == S_IDLE);
    assign bus.out_valid  = (r_fsm == S_DONE);
    assign bus.busy       = (r_fsm != S_IDLE);
    assign bus.ciphertext = r_state;
    assign bus.round_idx  = r_round;
endmodule

// File: tb/tb_aes128_enc_iter_ctrl.sv
// tb/tb_aes128_enc_iter_ctrl.sv - self-checking bench for aes128_enc_iter_ctrl
module tb_aes128_enc_iter_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    aes128_enc_iter_ctrl_if bus();

    aes128_enc_iter_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sbox_t [256];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its algebraic definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] k,
                                             output logic [127:0] rk10);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] ct;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) t[4*c + j] = s[4*((c + j) % 4) + j];
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) a[j] = t[4*c + j];
                for (int j = 0; j < 4; j++) begin
                    if (r < 10)
                        s[4*c + j] = gmul(8'h02, a[j]) ^ gmul(8'h03, a[(j+1)%4]) ^ a[(j+2)%4] ^ a[(j+3)%4];
                    else
                        s[4*c + j] = a[j];
                    s[4*c + j] = s[4*c + j] ^ w[4*r + c][31 - 8*j -: 8];
                end
            end
        end
        for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
        rk10 = {w[40], w[41], w[42], w[43]};
        return ct;
    endfunction

    task automatic run_job(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp_ct, input logic [127:0] exp_rk);
        int lat;
        @(negedge clk);
        check({tag, " in_ready idle"}, 128'(bus.in_ready), 128'(1));
        bus.plaintext = pt;
        bus.key       = k;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        check({tag, " in_ready drop"}, 128'(bus.in_ready), 128'(0));
        check({tag, " round_idx 1"}, 128'(bus.round_idx), 128'(1));
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'(10));
        check({tag, " ciphertext"}, bus.ciphertext, exp_ct);
        check({tag, " last rkey"}, dut.r_rkey, exp_rk);
        check({tag, " round_idx done"}, 128'(bus.round_idx), 128'(10));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " out_valid clr"}, 128'(bus.out_valid), 128'(0));
        check({tag, " in_ready back"}, 128'(bus.in_ready), 128'(1));
        check({tag, " round_idx 0"}, 128'(bus.round_idx), 128'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, 128'(bus.in_ready), 128'(1));
        check({tag, " out_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, " busy"}, 128'(bus.busy), 128'(0));
        check({tag, " ciphertext"}, bus.ciphertext, 128'h0);
        check({tag, " round_idx"}, 128'(bus.round_idx), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] pt, k, ct, rk, ct0;
        int n, bad, ovc, acc, done_n, cyc;
        int acc_cyc [$];
        int ridx [$];
        logic [127:0] expq [$];

        build_sbox();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.plaintext = '0;  bus.key = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post reset");

        run_job("appB", PT_B, KEY_B, CT_B, RK_B);
        ct = ref_enc(PT_C, KEY_C, rk);
        run_job("appC", PT_C, KEY_C, CT_C, rk);
        for (int i = 0; i < 4; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            ct = ref_enc(pt, k, rk);
            run_job("random", pt, k, ct, rk);
        end

        // Backpressure: hold DONE for 20 cycles.
        @(negedge clk);
        bus.plaintext = PT_B; bus.key = KEY_B; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
        check("bp reach done", 128'(bus.out_valid), 128'(1));
        ct0 = bus.ciphertext;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ciphertext !== ct0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
        end
        check("bp stable cycles", 128'(bad), 128'(0));
        check("bp ciphertext", bus.ciphertext, CT_B);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp handshake", 128'(bus.out_valid), 128'(0));
        check("bp in_ready", 128'(bus.in_ready), 128'(1));

        // Inputs toggled randomly while busy must not disturb the job.
        bus.plaintext = PT_B; bus.key = KEY_B; bus.in_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
            bus.key       = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        check("ignore ciphertext", bus.ciphertext, CT_B);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        ovc = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid) ovc++;
        end
        check("ignore single output", 128'(ovc), 128'(0));

        // Reset at round 5.
        bus.plaintext = PT_B; bus.key = KEY_B; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.round_idx != 4'd5 && n < 40) begin @(negedge clk); n++; end
        check("mid reach round 5", 128'(bus.round_idx), 128'(5));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        ovc = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid) ovc++;
        end
        check("mid no out_valid", 128'(ovc), 128'(0));
        ct = ref_enc(PT_C, KEY_C, rk);
        run_job("after reset appC", PT_C, KEY_C, CT_C, rk);

        // Back-to-back with out_ready held high, alternating App. B / App. C.
        bus.out_ready = 1'b1;
        acc = 0; done_n = 0; cyc = 0;
        while (done_n < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            ridx.push_back(int'(bus.round_idx));
            if (bus.out_valid) begin
                if (expq.size() > 0) check("b2b ciphertext", bus.ciphertext, expq.pop_front());
                else check("b2b spurious output", 128'(1), 128'(0));
                done_n++;
            end
            if (bus.in_ready) begin
                if (acc < 4) begin
                    bus.plaintext = (acc % 2 == 1) ? PT_C : PT_B;
                    bus.key       = (acc % 2 == 1) ? KEY_C : KEY_B;
                    expq.push_back((acc % 2 == 1) ? CT_C : CT_B);
                    bus.in_valid  = 1'b1;
                    acc_cyc.push_back(cyc);
                    acc++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b outputs", 128'(done_n), 128'(4));
        for (int i = 1; i < acc_cyc.size(); i++)
            check("b2b spacing", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'(12));
        if (acc_cyc.size() > 0 && ridx.size() >= acc_cyc[0] + 12) begin
            for (int j = 0; j <= 12; j++) begin
                int e;
                e = (j == 0 || j == 12) ? 0 : ((j == 11) ? 10 : j);
                check("b2b round_idx", 128'(ridx[acc_cyc[0] - 1 + j]), 128'(e));
            end
        end else begin
            check("b2b round_idx trace", 128'(ridx.size()), 128'(acc_cyc.size() > 0 ? acc_cyc[0] + 12 : 13));
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aes128_enc_iter_ctrl.md
# aes128_enc_iter_ctrl

Iterative AES-128 encryption controller. It accepts one plaintext/key pair over a valid/ready handshake and runs one AES round per clock on a single shared round datapath. Rounds 1–9 use the full round (sub_bytes, shift_rows, mix_columns, add_round_key); round 10 uses `encrypt_round10`. Round keys are expanded on the fly, one per cycle, and the ciphertext is returned over a second valid/ready handshake. The block sits between the host/bus interface and the combinational round modules, and is the only sequencer of those modules.

## Interface
- No parameters. The key size is fixed at AES-128 with Nr = 10.
- `clk` — input, 1 — single clock; all state updates on the rising edge.
- `rst_n` — input, 1 — reset, asynchronous assert, active-low.
- `in_valid` — input, 1 — `plaintext` and `key` are valid.
- `in_ready` — output, 1 — block can accept a job. High only in IDLE.
- `plaintext` — input, 128 — input block. Byte 0 is `[127:120]`; column-major state.
- `key` — input, 128 — cipher key. `w0 = key[127:96]` … `w3 = key[31:0]`.
- `out_valid` — output, 1 — `ciphertext` is valid. High only in DONE.
- `out_ready` — input, 1 — consumer accepts `ciphertext`.
- `ciphertext` — output, 128 — result, driven directly from the state register.
- `busy` — output, 1 — state is not IDLE.
- `round_idx` — output, 4 — current round counter, 0–10, for debug and coverage.

## Operation
- Registers:
  - `state_q[127:0]`
  - `rkey_q[127:0]`
  - `round_q[3:0]`
  - `fsm_q ∈ {IDLE, ROUND, DONE}`
- **IDLE**
  - `in_ready = 1`.
  - On `in_valid & in_ready`:
    - `state_q <= plaintext ^ key` (round-0 AddRoundKey)
    - `rkey_q <= key`
    - `round_q <= 1`
    - go to ROUND.
  - Otherwise hold.
- **ROUND**
  - Combinational next key `rk_next = expand(rkey_q, rcon[round_q])`:
    - `t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}`
    - `w4 = w0 ^ t`, `w5 = w1 ^ w4`, `w6 = w2 ^ w5`, `w7 = w3 ^ w6`.
  - Rcon for rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - If `round_q < 10`:
    - `state_q <= full_round(state_q, rk_next)`
    - `rkey_q <= rk_next`
    - `round_q <= round_q + 1`.
  - If `round_q == 10`:
    - `state_q <= encrypt_round10(state_q, rk_next)`
    - `rkey_q <= rk_next`
    - go to DONE.
  - `in_valid`, `plaintext` and `key` are ignored in this state. Changes to them do not affect the job in flight.
- **DONE**
  - `out_valid = 1`.
  - `ciphertext = state_q`, held stable until the handshake.
  - On `out_valid & out_ready`: `round_q <= 0`, go to IDLE.
- The round counter never exceeds 10. `round_q` values 11–15 are unreachable; if reached, go to IDLE.
- One datapath instance only. The full round and `encrypt_round10` share the `state_q` and `rk_next` inputs, and the output is selected by `round_q == 10`.

## Timing
- Reset (`rst_n` low, asynchronous, any state, including mid-round):
  - `fsm_q = IDLE`; `state_q`, `rkey_q`, `round_q` = 0.
  - `in_ready = 1`, `out_valid = 0`, `busy = 0`, `ciphertext = 0`, `round_idx = 0`.
  - The job in flight is discarded and no `out_valid` is produced for it.
- Latency: input handshake at edge T.
  - Rounds 1..10 execute at edges T+1..T+10.
  - `out_valid` is high from after edge T+10, i.e. 10 cycles after acceptance.
- `in_ready` drops the cycle after acceptance and returns the cycle after the output handshake.
- Minimum job-to-job spacing: 12 cycles (accept, 10 rounds, output handshake, then IDLE for one cycle).
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.
- Backpressure: `out_ready` low holds DONE indefinitely with `ciphertext` stable.

## Test plan
- **FIPS-197 App. B:** key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32; `out_valid` exactly 10 cycles after accept; `rkey_q` at DONE = d014f9a8c9ee2589e13f0cc8b6630ca6.
- **FIPS-197 App. C.1:** key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- **Backpressure:** hold `out_ready = 0` for 20 cycles after `out_valid` → `ciphertext` unchanged, `in_ready = 0` throughout, handshake completes on the first `out_ready = 1`.
- **Input ignored while busy:** toggle `in_valid`, `key` and `plaintext` randomly during ROUND → App. B ciphertext unchanged and only one output produced.
- **Reset mid-operation:** assert `rst_n = 0` at round 5 for 1 cycle → all outputs at reset values immediately, no `out_valid`; a following App. C.1 job produces the correct ciphertext.
- **Back-to-back:** `in_valid` and `out_ready` held high with the two vectors alternating → correct ciphertexts in order, accept spacing exactly 12 cycles, `round_idx` sequence 0, 1..10, 10 (DONE), 0.
